// File: rtl/hazard_issue_ctrl_pkg.sv
// Shared pipeline definitions: issue-controller states, id_ctrl bit positions
// and the bubble control word used by the decoder, ID/EX latch and hazard logic.
package hazard_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      FLUSH
   } hz_state_t;

   localparam int unsigned CTRL_ALUOP1   = 7;
   localparam int unsigned CTRL_ALUOP2   = 6;
   localparam int unsigned CTRL_ALUOP3   = 5;
   localparam int unsigned CTRL_ALUSRC   = 4;
   localparam int unsigned CTRL_MEMREAD  = 3;
   localparam int unsigned CTRL_MEMWRITE = 2;
   localparam int unsigned CTRL_MEMTOREG = 1;
   localparam int unsigned CTRL_REGWRITE = 0;

   localparam logic [7:0] CTRL_BUBBLE = 8'h00;

endpackage

// File: rtl/hazard_issue_ctrl_lu_detect.sv
// Combinational load-use comparator: decoded sources against the load in ID/EX.
module hazard_lu_detect (
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   output logic       lu
);

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign lu = ex_memread && (ex_rd != 5'd0) && id_valid &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_issue_ctrl.sv
// ID-stage hazard/issue controller driving the ID/EX write side.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_issue_ctrl
   import hazard_issue_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [7:0]  id_ctrl,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic        mem_busy,
   input  logic        branch_taken,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_hold,
   output logic [7:0]  idex_ctrl,
   output logic        idex_bubble
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);

   hz_state_t  state, state_nxt;
   logic [2:0] fcnt, fcnt_nxt;
   logic       lu;

   hazard_lu_detect u_lu (
      .ex_memread  (ex_memread),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .lu          (lu)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // MEM_WAIT with mem_busy low shares the RUN path, so it is not decoded separately
   always_comb begin
      state_nxt   = state;
      fcnt_nxt    = fcnt;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_hold   = 1'b0;
      idex_ctrl   = CTRL_BUBBLE;
      idex_bubble = 1'b1;
      if (!rst_n) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
      end else if (mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_hold  = 1'b1;
         if (state != FLUSH) state_nxt = MEM_WAIT;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FCNT_RELOAD;
         end else begin
            state_nxt = RUN;
            fcnt_nxt  = '0;
         end
      end else if (state == FLUSH) begin
         ifid_flush = 1'b1;
         if (fcnt <= 3'd1) begin
            state_nxt = RUN;
            fcnt_nxt  = '0;
         end else begin
            fcnt_nxt  = fcnt - 3'd1;
         end
      end else if (lu) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         state_nxt  = RUN;
      end else begin
         state_nxt   = RUN;
         idex_ctrl   = id_valid ? id_ctrl : CTRL_BUBBLE;
         idex_bubble = !id_valid;
      end
   end

`ifdef HAZARD_PERF_EN
   logic br_accept;
   assign br_accept = rst_n && !mem_busy && branch_taken;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (!pc_write && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (br_accept && (perf_flush_cnt != '1))
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/hazard_issue_ctrl.md
# hazard_issue_ctrl

ID-stage hazard and issue controller that drives the write side of the ID/EX pipeline latch. It decides each cycle whether the decoded instruction enters ID/EX or a bubble is inserted. It also freezes PC and IF/ID on load-use hazards and data-memory wait states, and flushes wrong-path instructions after a taken branch resolved in EX. It sits between the decoder/register file and the ID/EX latch, and observes the ID/EX and EX/MEM contents.

## Interface
Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed and ID/EX receives bubbles after branch_taken (1..7).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset: one clock, synchronous and active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1, id_rs2  in  5 each  source register numbers of the decoded instruction
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1/rs2
- id_ctrl  in  8  decoded control: [7]aluop1 [6]aluop2 [5]aluop3 [4]alusrc [3]memread [2]memwrite [1]memtoreg [0]regwrite
- ex_memread  in  1  memread currently held in ID/EX
- ex_rd  in  5  writeregister currently held in ID/EX
- mem_busy  in  1  data memory not ready; whole pipeline must freeze
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_hold  out  1  ID/EX keeps its current contents
- idex_ctrl  out  8  control vector presented to ID/EX (id_ctrl or 8'h00 bubble)
- idex_bubble  out  1  idex_ctrl is a bubble this cycle

## Operation
- States: RUN, MEM_WAIT, FLUSH. 3-bit flush counter fcnt.
- Load-use hazard (lu): ex_memread & ex_rd != 0 & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority within a cycle: mem_busy > branch_taken > lu > normal issue.
- RUN:
  - mem_busy: pc_write=0, ifid_write=0, idex_hold=1; next state MEM_WAIT.
  - else branch_taken: ifid_flush=1, pc_write=1, idex bubble. If FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES-1, else stay RUN.
  - else lu: pc_write=0, ifid_write=0, idex bubble. No state change; the hazard clears naturally the next cycle.
  - else: pc_write=1, ifid_write=1, idex_ctrl=id_ctrl; idex_bubble=0 if id_valid, else a bubble is issued.
- MEM_WAIT:
  - Same outputs as the mem_busy case in RUN while mem_busy=1.
  - The first cycle mem_busy=0 behaves exactly as RUN, including branch_taken and lu; the state returns to RUN or enters FLUSH accordingly.
- FLUSH:
  - ifid_flush=1, idex bubble, pc_write=1, fcnt decrements; go to RUN when fcnt reaches 1.
  - mem_busy in FLUSH freezes everything, and fcnt holds.
  - A new branch_taken reloads fcnt=FLUSH_CYCLES-1.
- Bubble means idex_ctrl=8'h00 and idex_bubble=1; regwrite and memwrite are therefore 0.
- ex_rd==0 never causes a stall.

## Timing
- Outputs are combinational from state, fcnt and current inputs: zero-cycle latency hazard response. State and fcnt update on posedge clk.
- While rst_n=0 the outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_hold=0, idex_ctrl=8'h00, idex_bubble=1.
- On the clock edge with rst_n=0: state=RUN, fcnt=0, and perf counters clear.
- Reset mid-FLUSH or mid-MEM_WAIT abandons the operation; there is no residual stall after reset.
- A load-use stall lasts exactly 1 cycle per hazard. Back-to-back dependent loads each stall once.
- branch_taken asserted together with lu: the flush wins, and no stall cycle is added.

## Configuration
- HAZARD_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on every cycle with pc_write=0.
  - perf_flush_cnt increments on every branch_taken accepted in RUN or FLUSH.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- HAZARD_PERF_EN undefined: the counters and their ports are absent, and behaviour is otherwise identical.

## Structure
- Shared pipeline package holds:
  - the state enum (RUN/MEM_WAIT/FLUSH);
  - the id_ctrl bit-index constants;
  - the CTRL_BUBBLE=8'h00 constant, also used by the decoder and the ID/EX latch.
- One sub-module, hazard_lu_detect: the combinational load-use comparator, reused by the forwarding checks.

## Test plan
- ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> same cycle pc_write=0, ifid_write=0, idex_ctrl=00, idex_bubble=1; next cycle with ex_memread=0 -> idex_ctrl=id_ctrl.
- Same as above but ex_rd=0 -> no stall, idex_ctrl=id_ctrl.
- FLUSH_CYCLES=2, branch_taken for 1 cycle -> ifid_flush=1 and bubbles for exactly 2 cycles, then RUN.
- mem_busy high for 3 cycles during FLUSH -> idex_hold=1, pc_write=0 for 3 cycles; flush then completes its remaining cycle.
- branch_taken and lu in the same cycle -> pc_write=1, ifid_flush=1, a single bubble, no stall.
- Assert rst_n=0 in MEM_WAIT with mem_busy=1, release with mem_busy=0 -> first cycle after reset pc_write=1, state RUN; with HAZARD_PERF_EN, perf_stall_cnt=0.
